// File: rtl/simple_dma_pkg.sv
// simple_dma_pkg: shared definitions for the simple DMA controller.
// Holds the controller FSM state encoding and the per-word byte address increment.
package simple_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MEM   = 3'd1,
        RDATA = 3'd2,
        XFER  = 3'd3,
        DONE  = 3'd4,
        DROP  = 3'd5
    } dma_state_e;

    // Byte address step between consecutive 16-bit words.
    localparam logic [15:0] WORD_INC = 16'd2;

endpackage

// File: rtl/dma_addr_gen.sv
// dma_addr_gen: word address and remaining-word counter for the DMA controller.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   i_load           load start word address and word count
//   i_word_addr[15]  start word address (byte address [15:1])
//   i_count[16]      number of words to move (non-zero when loaded)
//   i_step           one word completed: advance address, decrement count
//   o_word_addr[15]  current word address
//   o_last           current word is the final one
module dma_addr_gen
    import simple_dma_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic [14:0] i_word_addr,
    input  logic [15:0] i_count,
    input  logic        i_step,
    output logic [14:0] o_word_addr,
    output logic        o_last
);

    logic [14:0] r_addr;
    logic [15:0] r_count;

    // Address is kept in word units; the 15-bit add gives the 0xFFFE -> 0x0000 byte wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_addr  <= i_word_addr;
            r_count <= i_count;
        end else if (i_step) begin
            r_addr  <= r_addr + WORD_INC[15:1];
            r_count <= r_count - 16'd1;
        end
    end

    assign o_word_addr = r_addr;
    assign o_last      = (r_count == 16'd1);

endmodule

// File: rtl/simple_dma_controller.sv
// simple_dma_controller: single-channel DMA between a 16-bit memory port and a device.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   dma_rqst, dma_rd_wr          device request (level) and direction (1 = mem->device)
//   dma_start_address[16]        byte start address (bit 0 ignored)
//   dma_num_words[16]            words to move
//   dev_ack, dev_out[16]         device per-word handshake and write data
//   dev_in[16], dma_ack          read data to device and per-word strobe
//   dma_end_flag                 one-cycle end-of-transfer pulse
//   dma_addr[15], dma_en,        memory word address, access request,
//   dma_we[2], dma_din[16]       byte write enables, write data
//   dma_priority                 constant PRIORITY
//   dma_dout[16], dma_ready,     memory read data, access accepted,
//   dma_resp                     error response
//   dma_error                    sticky abort flag (only with DMA_ERR_EN)
// Build option: define DMA_ERR_EN to abort on dma_resp and expose dma_error.
module simple_dma_controller
    import simple_dma_pkg::*;
#(
    parameter logic PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rqst,
    input  logic        dma_rd_wr,
    input  logic [15:0] dma_start_address,
    input  logic [15:0] dma_num_words,
    input  logic        dev_ack,
    input  logic [15:0] dev_out,
    output logic [15:0] dev_in,
    output logic        dma_ack,
    output logic        dma_end_flag,
    output logic [14:0] dma_addr,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic [15:0] dma_din,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp
`ifdef DMA_ERR_EN
    ,
    output logic        dma_error
`endif
);

    dma_state_e  r_state, w_state_d;
    logic        r_rd;        // latched direction
    logic        r_drop;      // request went low while waiting in MEM
    logic [15:0] r_dev_in;
    logic [15:0] r_dma_din;
    logic        w_load, w_step, w_cap_rd, w_cap_wr, w_err_set, w_resp_err, w_last;
    logic [14:0] w_word_addr;
    logic        w_unused;

`ifdef DMA_ERR_EN
    logic r_error;
    // Write errors are reported alongside dma_ready, read errors in RDATA.
    assign w_resp_err = dma_resp;
    assign w_unused   = dma_start_address[0];
`else
    assign w_resp_err = 1'b0;
    assign w_unused   = ^{dma_start_address[0], dma_resp, w_err_set};
`endif

    dma_addr_gen u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_word_addr (dma_start_address[15:1]),
        .i_count     (dma_num_words),
        .i_step      (w_step),
        .o_word_addr (w_word_addr),
        .o_last      (w_last)
    );

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_cap_rd  = 1'b0;
        w_cap_wr  = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (dma_rqst) begin
                    if (dma_num_words != 16'd0) begin
                        w_load    = 1'b1;
                        w_state_d = dma_rd_wr ? MEM : XFER;
                    end else begin
                        w_state_d = DONE;
                    end
                end
            end
            MEM: begin
                // The access is always completed before honouring a dropped request.
                if (dma_ready) begin
                    if (!dma_rqst || r_drop) begin
                        w_state_d = IDLE;
                    end else if (r_rd) begin
                        w_state_d = RDATA;
                    end else if (w_resp_err) begin
                        w_err_set = 1'b1;
                        w_state_d = DONE;
                    end else begin
                        w_step    = 1'b1;
                        w_state_d = w_last ? DONE : XFER;
                    end
                end
            end
            RDATA: begin
                if (!dma_rqst) begin
                    w_state_d = IDLE;
                end else if (w_resp_err) begin
                    w_err_set = 1'b1;
                    w_state_d = DONE;
                end else begin
                    w_cap_rd  = 1'b1;
                    w_state_d = XFER;
                end
            end
            XFER: begin
                if (!dma_rqst) begin
                    w_state_d = IDLE;
                end else if (dev_ack) begin
                    if (r_rd) begin
                        w_step    = 1'b1;
                        w_state_d = w_last ? DONE : MEM;
                    end else begin
                        w_cap_wr  = 1'b1;
                        w_state_d = MEM;
                    end
                end
            end
            DONE:    w_state_d = DROP;
            DROP:    if (!dma_rqst) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_rd      <= 1'b0;
            r_drop    <= 1'b0;
            r_dev_in  <= '0;
            r_dma_din <= '0;
        end else begin
            r_state <= w_state_d;
            r_drop  <= (r_state == MEM) ? (r_drop | ~dma_rqst) : 1'b0;
            if (w_load)   r_rd      <= dma_rd_wr;
            if (w_cap_rd) r_dev_in  <= dma_dout;
            if (w_cap_wr) r_dma_din <= dev_out;
        end
    end

`ifdef DMA_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (r_state == IDLE && dma_rqst) begin
            r_error <= 1'b0;
        end else if (w_err_set) begin
            r_error <= 1'b1;
        end
    end
    assign dma_error = r_error;
`endif

    assign dma_en       = (r_state == MEM);
    assign dma_we       = (r_state == MEM && !r_rd) ? 2'b11 : 2'b00;
    assign dma_ack      = (r_state == XFER) && dma_rqst && dev_ack;
    assign dma_end_flag = (r_state == DONE);
    assign dma_addr     = w_word_addr;
    assign dev_in       = r_dev_in;
    assign dma_din      = r_dma_din;
    assign dma_priority = PRIORITY;

endmodule

// File: tb/tb_simple_dma_controller.sv
// tb_simple_dma_controller: directed bench for simple_dma_controller with a
// behavioural memory and a negedge monitor logging accesses, acks and end pulses.
// With DMA_ERR_EN defined an abort-on-error scenario is added.
module tb_simple_dma_controller;
    import simple_dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_rqst, dma_rd_wr, dev_ack, dma_ready, dma_resp;
    logic [15:0] dma_start_address, dma_num_words, dev_out, dma_dout;
    logic [15:0] dev_in, dma_din;
    logic        dma_ack, dma_end_flag, dma_en, dma_priority;
    logic [14:0] dma_addr;
    logic [1:0]  dma_we;
`ifdef DMA_ERR_EN
    logic        dma_error;
`endif

    simple_dma_controller dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dma_rqst          (dma_rqst),
        .dma_rd_wr         (dma_rd_wr),
        .dma_start_address (dma_start_address),
        .dma_num_words     (dma_num_words),
        .dev_ack           (dev_ack),
        .dev_out           (dev_out),
        .dev_in            (dev_in),
        .dma_ack           (dma_ack),
        .dma_end_flag      (dma_end_flag),
        .dma_addr          (dma_addr),
        .dma_en            (dma_en),
        .dma_we            (dma_we),
        .dma_din           (dma_din),
        .dma_priority      (dma_priority),
        .dma_dout          (dma_dout),
        .dma_ready         (dma_ready),
        .dma_resp          (dma_resp)
`ifdef DMA_ERR_EN
        ,
        .dma_error         (dma_error)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start;
    int end_cyc;
    int ack_cnt;
    int end_cnt;
    logic [14:0] acc_addr[$];
    logic [1:0]  acc_we[$];
    logic [15:0] acc_din[$];
    logic [15:0] ack_data[$];
    logic [15:0] mem [0:32767];
    logic        err_en = 1'b0;
    logic [14:0] err_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: read data and response appear the cycle after an accepted access.
    always @(posedge clk) begin
        if (dma_en && dma_ready) begin
            if (dma_we == 2'b11) mem[dma_addr] <= dma_din;
            else                 dma_dout <= mem[dma_addr];
            dma_resp <= err_en && (dma_addr == err_addr);
        end else begin
            dma_resp <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (dma_en && dma_ready) begin
            acc_addr.push_back(dma_addr);
            acc_we.push_back(dma_we);
            acc_din.push_back(dma_din);
        end
        if (dma_ack) begin
            ack_cnt++;
            ack_data.push_back(dev_in);
        end
        if (dma_end_flag) begin
            end_cnt++;
            end_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a transfer, then scramble the setup inputs to show they are ignored after latch.
    task automatic start_xfer(input logic rd, input logic [15:0] addr, input logic [15:0] n);
        acc_addr.delete(); acc_we.delete(); acc_din.delete(); ack_data.delete();
        ack_cnt = 0;
        end_cnt = 0;
        end_cyc = -1;
        tick(1);
        dma_rd_wr         = rd;
        dma_start_address = addr;
        dma_num_words     = n;
        dma_rqst          = 1'b1;
        t_start           = cyc;
        tick(1);
        dma_rd_wr         = ~rd;
        dma_start_address = 16'h1234;
        dma_num_words     = 16'd9;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (end_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
    endtask

    task automatic release_rqst();
        dma_rqst = 1'b0;
        tick(3);
    endtask

    initial begin
        reset_n = 1'b0; dma_rqst = 1'b0; dma_rd_wr = 1'b0; dev_ack = 1'b1;
        dma_ready = 1'b1; dma_resp = 1'b0; dma_dout = '0; dev_out = '0;
        dma_start_address = '0; dma_num_words = '0;
        mem[15'h100] = 16'hA001; mem[15'h101] = 16'hA002; mem[15'h102] = 16'hA003;
        mem[15'h7FFF] = 16'hC001; mem[15'h0000] = 16'hC002;
        mem[15'h200] = 16'hB001; mem[15'h201] = 16'hB002;
        tick(3);
        check_eq("rst_ctrl", {dma_en, dma_we, dma_ack, dma_end_flag}, 32'h0);
        check_eq("rst_addr", dma_addr, 32'h0);
        check_eq("rst_data", {dev_in, dma_din}, 32'h0);
        check_eq("priority", dma_priority, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // Read, 3 words from byte 0x0200.
        start_xfer(1'b1, 16'h0200, 16'd3);
        wait_end(40);
        check_eq("rd_nacc", acc_addr.size(), 3);
        check_eq("rd_a0", acc_addr[0], 15'h100);
        check_eq("rd_a1", acc_addr[1], 15'h101);
        check_eq("rd_a2", acc_addr[2], 15'h102);
        check_eq("rd_we", {acc_we[0], acc_we[1], acc_we[2]}, 32'h0);
        check_eq("rd_acks", ack_cnt, 3);
        check_eq("rd_d0", ack_data[0], 16'hA001);
        check_eq("rd_d1", ack_data[1], 16'hA002);
        check_eq("rd_d2", ack_data[2], 16'hA003);
        check_eq("rd_cycles", end_cyc - t_start, 10);
        tick(2);
        check_eq("rd_ends", end_cnt, 1);
        release_rqst();

        // Write, 2 words of 0x7777 to byte 0x0300.
        dev_out = 16'h7777;
        start_xfer(1'b0, 16'h0300, 16'd2);
        wait_end(40);
        check_eq("wr_nacc", acc_addr.size(), 2);
        check_eq("wr_a0", acc_addr[0], 15'h180);
        check_eq("wr_a1", acc_addr[1], 15'h181);
        check_eq("wr_we", {acc_we[0], acc_we[1]}, 32'hF);
        check_eq("wr_din", {acc_din[0], acc_din[1]}, 32'h77777777);
        check_eq("wr_acks", ack_cnt, 2);
        check_eq("wr_cycles", end_cyc - t_start, 5);
        tick(2);
        check_eq("wr_ends", end_cnt, 1);
        release_rqst();

        // Zero words: no memory access, end pulse one cycle after the request.
        start_xfer(1'b1, 16'h0400, 16'd0);
        wait_end(20);
        tick(2);
        check_eq("z_nacc", acc_addr.size(), 0);
        check_eq("z_acks", ack_cnt, 0);
        check_eq("z_ends", end_cnt, 1);
        check_eq("z_cycles", end_cyc - t_start, 1);
        release_rqst();

        // Address wrap from 0xFFFE.
        start_xfer(1'b1, 16'hFFFE, 16'd2);
        wait_end(40);
        check_eq("wrap_a0", acc_addr[0], 15'h7FFF);
        check_eq("wrap_a1", acc_addr[1], 15'h0000);
        check_eq("wrap_d", {ack_data[0], ack_data[1]}, 32'hC001C002);
        release_rqst();

        // Stalls: memory not ready for 4 cycles, device not ready for 3.
        dma_ready = 1'b0;
        dev_ack   = 1'b0;
        start_xfer(1'b1, 16'h0400, 16'd2);
        tick(3);
        check_eq("st_hold", {dma_en, 1'b0, dma_addr}, {1'b1, 1'b0, 15'h200});
        check_eq("st_nacc0", acc_addr.size(), 0);
        dma_ready = 1'b1;
        tick(5);
        check_eq("st_noack", ack_cnt, 0);
        check_eq("st_nacc1", acc_addr.size(), 1);
        dev_ack = 1'b1;
        wait_end(40);
        check_eq("st_acks", ack_cnt, 2);
        check_eq("st_nacc", acc_addr.size(), 2);
        check_eq("st_d", {ack_data[0], ack_data[1]}, 32'hB001B002);
        release_rqst();

        // Request dropped while waiting in XFER: back to idle, no ack or end pulse.
        dev_ack = 1'b0;
        start_xfer(1'b1, 16'h0200, 16'd2);
        tick(3);
        dma_rqst = 1'b0;
        tick(4);
        check_eq("drop_acks", ack_cnt, 0);
        check_eq("drop_ends", end_cnt, 0);
        check_eq("drop_state", dut.r_state, IDLE);
        dev_ack = 1'b1;

        // Reset in the middle of a transfer.
        start_xfer(1'b1, 16'h0200, 16'd3);
        tick(3);
        reset_n  = 1'b0;
        dma_rqst = 1'b0;
        #1;
        check_eq("mr_ctrl", {dma_en, dma_we, dma_ack, dma_end_flag}, 32'h0);
        check_eq("mr_addr", dma_addr, 32'h0);
        check_eq("mr_data", {dev_in, dma_din}, 32'h0);
        check_eq("mr_state", dut.r_state, IDLE);
        tick(2);
        reset_n = 1'b1;
        tick(2);

`ifdef DMA_ERR_EN
        // Error response on word 2 of 4 aborts the read.
        mem[15'h300] = 16'hD001; mem[15'h301] = 16'hD002;
        err_en   = 1'b1;
        err_addr = 15'h301;
        start_xfer(1'b1, 16'h0600, 16'd4);
        wait_end(40);
        tick(4);
        check_eq("err_flag", dma_error, 1);
        check_eq("err_ends", end_cnt, 1);
        check_eq("err_acks", ack_cnt, 1);
        check_eq("err_nacc", acc_addr.size(), 2);
        release_rqst();
        check_eq("err_nacc2", acc_addr.size(), 2);
        err_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/simple_dma_controller.md
SIMPLE_DMA_CONTROLLER -- requirements
Module: simple_dma_controller

Interface
REQ-001 Parameter PRIORITY, default 1'b0: constant value driven on dma_priority.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 dma_rqst  in  1  device transfer request (level).
REQ-005 dma_rd_wr  in  1  1: memory->device (read); 0: device->memory (write).
REQ-006 dma_start_address  in  16  byte start address; bit 0 ignored.
REQ-007 dma_num_words  in  16  number of 16-bit words.
REQ-008 dev_ack  in  1  device ready for per-word handshake.
REQ-009 dev_out  in  16  write data from device.
REQ-010 dev_in  out  16  read data to device.
REQ-011 dma_ack  out  1  one-cycle per-word strobe to device.
REQ-012 dma_end_flag  out  1  one-cycle end-of-transfer pulse.
REQ-013 dma_addr  out  15  memory word address (byte address [15:1]).
REQ-014 dma_en  out  1  memory access request.
REQ-015 dma_we  out  2  byte write enables; 2'b11 on write, 2'b00 on read.
REQ-016 dma_din  out  16  memory write data.
REQ-017 dma_priority  out  1  equals PRIORITY.
REQ-018 dma_dout  in  16  memory read data, valid the cycle after dma_ready is sampled high with dma_en.
REQ-019 dma_ready  in  1  memory accepted current access.
REQ-020 dma_resp  in  1  memory error response, valid with dma_dout.

Function
REQ-021 FSM states SHALL be IDLE, MEM, RDATA, XFER, DONE, DROP.
REQ-022 IDLE: dma_rqst high with dma_num_words!=0 -> latch address and count; next state XFER if write, MEM if read.
REQ-023 IDLE: dma_rqst high with dma_num_words==0 -> DONE; no memory access, no dma_ack.
REQ-024 MEM: dma_en=1 and dma_addr=current address, held until dma_ready is sampled high; read -> RDATA, write -> word-complete.
REQ-025 RDATA: capture dma_dout into dev_in register -> XFER.
REQ-026 XFER: when dev_ack=1, dma_ack=1 for exactly that cycle; read -> word-complete; write -> capture dev_out into dma_din -> MEM.
REQ-027 Word-complete: address+=2 (16-bit wrap, 0xFFFE->0x0000), count-=1; count reaches 0 -> DONE, else next word.
REQ-028 DONE: dma_end_flag=1 for one cycle -> DROP; DROP waits for dma_rqst low -> IDLE.
REQ-029 Minimum throughput with dma_ready=1 and dev_ack=1: read 3 cycles/word, write 2 cycles/word.
REQ-030 dma_rqst low in XFER or RDATA -> IDLE next cycle; no dma_ack, no end flag.
REQ-031 dma_rqst low in MEM -> finish the pending access, then IDLE; no end flag.
REQ-032 dma_start_address, dma_num_words and dma_rd_wr changes after latch SHALL be ignored until IDLE.

Reset
REQ-033 reset_n low SHALL force IDLE immediately, at any point mid-transfer: dma_en=0, dma_we=0, dma_ack=0, dma_end_flag=0, dma_addr=0, dma_din=0, dev_in=0, count=0.

Configuration
REQ-034 DMA_ERR_EN defined: dma_resp=1 in RDATA or at write completion -> abort, dma_end_flag pulse, sticky output dma_error (1 bit) set; cleared on next IDLE start.
REQ-035 DMA_ERR_EN undefined: dma_resp ignored; dma_error port absent.

Structure
REQ-036 Shared package simple_dma_pkg SHALL hold FSM state encodings and WORD_INC=2.
REQ-037 Address/count generator SHALL be sub-module dma_addr_gen (load, step, last flag).

Verification
REQ-038 Read, start 0x0200, 3 words, ready=1, dev_ack=1 -> dma_addr 0x100,0x101,0x102; three dma_ack; dev_in matches memory; end pulse.
REQ-039 Write, start 0x0300, 2 words, dev_out=0x7777 -> two writes of 0x7777, dma_we=11, at 0x180 and 0x181; one end pulse.
REQ-040 dma_num_words=0 -> no dma_en; dma_end_flag exactly one cycle later.
REQ-041 Start 0xFFFE, 2 words -> second access at dma_addr 0x0000.
REQ-042 dma_ready low 4 cycles and dev_ack low 3 cycles -> stalls held, no lost or duplicated dma_ack; reset_n low mid-transfer -> all outputs 0, FSM IDLE.
REQ-043 DMA_ERR_EN defined, dma_resp=1 on word 2 of 4 -> abort, dma_error=1, end pulse, no further dma_en.
